// File: rtl/accum_sched_pkg.sv
// Shared types and default sizing for the accumulate-loop scheduler.
package accum_sched_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when the
// current grant is actually taken.
module rr_arb2
  import accum_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  // High when requester 1 wins a tie.
  logic prio1_q, prio1_d;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio1_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_comb begin
    prio1_d = prio1_q;
    if (update_i) prio1_d = grant_o[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio1_q <= 1'b0;
    else     prio1_q <= prio1_d;
  end

endmodule

// File: rtl/accum_loop_sched.sv
// Accepts one job at a time from two requesters and repeatedly adds b to a,
// skipping any addition that would overflow and flagging that it happened.
//
// state   | meaning
// IDLE    | waiting for a job, ready to the granted requester
// RUN     | one add iteration per cycle until iter reaches 1
// DONE    | result presented, held until rsp_ready
module accum_loop_sched
  import accum_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CNT_W-1:0]  req0_count,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CNT_W-1:0]  req1_count,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_id,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic              ovf_q, ovf_d;
  logic              id_q, id_d;

  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              accept;
  logic              idle;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [CNT_W-1:0]  cnt_sel;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req1_valid, req0_valid}),
    .update_i (accept),
    .grant_o  (grant)
  );

  // Ready is also masked by rst so nothing looks accepted while reset is held.
  assign idle   = (state_q == ST_IDLE);
  assign ready  = grant & {2{idle & ~rst}};
  assign accept = |(ready & {req1_valid, req0_valid});

  assign a_sel   = grant[1] ? req1_a     : req0_a;
  assign b_sel   = grant[1] ? req1_b     : req0_b;
  assign cnt_sel = grant[1] ? req1_count : req0_count;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    id_d    = id_q;
    sum     = {1'b0, acc_q} + {1'b0, b_q};
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d   = a_sel;
          b_d     = b_sel;
          ovf_d   = 1'b0;
          iter_d  = cnt_sel;
          id_d    = grant[1];
          state_d = (cnt_sel != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        // An overflowing add still burns its iteration; acc keeps its value.
        if (sum[DATA_W]) ovf_d = 1'b1;
        else             acc_d = sum[DATA_W-1:0];
        iter_d = iter_q - CNT_W'(1);
        if (iter_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
    end
  end

  assign req0_ready   = ready[0];
  assign req1_ready   = ready[1];
  assign rsp_valid    = (state_q == ST_DONE);
  assign rsp_result   = acc_q;
  assign rsp_overflow = ovf_q;
  assign rsp_id       = id_q;
  assign busy         = ~idle;

endmodule

// File: tb/tb_accum_loop_sched.sv
// Randomized scoreboard bench for accum_loop_sched with a plain-arithmetic
// reference model and an independent round-robin grant model.
module tb_accum_loop_sched;

  localparam int DW = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0] req0_count, req1_count;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_overflow, rsp_id, busy;

  always #5 clk = ~clk;

  accum_loop_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_count   (req0_count),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_count   (req1_count),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_id       (rsp_id),
    .busy         (busy)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          ovf;
    logic          id;
    int            acc_cyc;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  logic id_log[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   dropped = 0;
  int   rsp_mode = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Saturating-by-skip accumulation straight from the job description.
  function automatic void ref_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    input int cnt, output logic [DW-1:0] r, output logic o);
    int acc;
    acc = int'(a);
    o = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (acc + int'(b) > (1 << DW) - 1) o = 1'b1;
      else acc = acc + int'(b);
    end
    r = DW'(acc);
  endfunction

  // Acceptance side: predicts ready/busy, and pushes expected results.
  initial begin : issue_mon
    bit         idle;
    bit         prio1;
    logic [1:0] v, g;
    exp_t       e;
    idle = 1'b1;
    prio1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle = 1'b1;
        prio1 = 1'b0;
      end else begin
        v = {req1_valid, req0_valid};
        g = (v == 2'b11) ? (prio1 ? 2'b10 : 2'b01) : v;
        if (!idle) g = 2'b00;
        chk("ready", {30'd0, req1_ready, req0_ready}, {30'd0, g});
        chk("busy", {31'd0, busy}, {31'd0, !idle});
        if (g != 2'b00) begin
          e.cnt = g[1] ? int'(req1_count) : int'(req0_count);
          ref_model(g[1] ? req1_a : req0_a, g[1] ? req1_b : req0_b, e.cnt, e.res, e.ovf);
          e.id = g[1];
          e.acc_cyc = cyc;
          sb.push_back(e);
          id_log.push_back(g[1]);
          idle = 1'b0;
          prio1 = g[0];
          acc_cnt++;
        end else if (rsp_valid && rsp_ready) begin
          idle = 1'b1;
        end
      end
    end
  end

  // Response side: pops and compares whenever a result is presented.
  initial begin : rsp_mon
    bit   first;
    exp_t e;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        first = 1'b1;
      end else if (rsp_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 want 0 (t=%0t)", $time);
        end else begin
          e = sb[0];
          if (first) chk("latency", cyc - e.acc_cyc, e.cnt + 1);
          chk("result", {24'd0, rsp_result}, {24'd0, e.res});
          chk("overflow", {31'd0, rsp_overflow}, {31'd0, e.ovf});
          chk("id", {31'd0, rsp_id}, {31'd0, e.id});
          first = 1'b0;
          if (rsp_ready) begin
            void'(sb.pop_front());
            first = 1'b1;
            rsp_cnt++;
          end
        end
      end
    end
  end

  // Consumer: always ready, random, or hold each result for three cycles.
  initial begin : rdy_drv
    int hc;
    hc = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rsp_mode)
        0: rsp_ready = 1'b1;
        1: rsp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (rsp_valid) begin
            if (hc == 3) begin
              rsp_ready = 1'b1;
              hc = 0;
            end else begin
              rsp_ready = 1'b0;
              hc++;
            end
          end else begin
            rsp_ready = 1'b0;
            hc = 0;
          end
        end
      endcase
    end
  end

  task automatic issue(input logic [1:0] sel,
                       input logic [DW-1:0] a0, input logic [DW-1:0] b0, input logic [CW-1:0] c0,
                       input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic [CW-1:0] c1);
    int start;
    bit ok;
    start = acc_cnt;
    ok = 1'b0;
    req0_a = a0; req0_b = b0; req0_count = c0;
    req1_a = a1; req1_b = b1; req1_count = c1;
    req0_valid = sel[0];
    req1_valid = sel[1];
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt > start) begin
        ok = 1'b1;
        break;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: got no acceptance want acceptance");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy want idle");
    end
  endtask

  task automatic rnd_job();
    logic [1:0] sel;
    sel = 2'($urandom_range(1, 3));
    issue(sel, DW'($urandom), DW'($urandom), CW'($urandom),
               DW'($urandom), DW'($urandom), CW'($urandom));
  endtask

  initial begin : stim
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'h11; req0_b = 8'h22; req0_count = 3'd2;
    req1_a = 8'h33; req1_b = 8'h44; req1_count = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_result", {24'd0, rsp_result}, 0);
    chk("rst_overflow", {31'd0, rsp_overflow}, 0);
    chk("rst_id", {31'd0, rsp_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;

    // Directed jobs: plain sum, overflow hold, zero-count passthrough.
    rsp_mode = 0;
    issue(2'b01, 8'd10, 8'd20, 3'd3, 8'd0, 8'd0, 3'd0);
    issue(2'b01, 8'h5A, 8'hFF, 3'd0, 8'd0, 8'd0, 3'd0);
    issue(2'b10, 8'd0, 8'd0, 3'd0, 8'd200, 8'd30, 3'd3);
    wait_idle();

    // Both requesters contending with held results: grants must alternate.
    rsp_mode = 2;
    id_log.delete();
    for (int k = 0; k < 4; k++)
      issue(2'b11, DW'($urandom), DW'($urandom), 3'd1, DW'($urandom), DW'($urandom), 3'd1);
    wait_idle();
    chk("alt_count", id_log.size(), 4);
    for (int k = 0; k < 4 && k < id_log.size(); k++)
      chk($sformatf("alt_grant%0d", k), {31'd0, id_log[k]}, k % 2);

    // Reset in the second RUN cycle of a long job.
    rsp_mode = 0;
    issue(2'b01, 8'd1, 8'd1, 3'd7, 8'd0, 8'd0, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    dropped++;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_result", {24'd0, rsp_result}, 0);
    chk("mid_rst_overflow", {31'd0, rsp_overflow}, 0);
    chk("mid_rst_id", {31'd0, rsp_id}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    issue(2'b10, 8'd0, 8'd0, 3'd0, 8'd7, 8'd9, 3'd4);
    wait_idle();

    // Randomized traffic under all consumer behaviours.
    for (int n = 0; n < 40; n++) begin
      rsp_mode = int'($urandom_range(0, 2));
      rnd_job();
    end
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    chk("rsp_count", rsp_cnt, acc_cnt - dropped);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accum_loop_sched.md
ACCUM_LOOP_SCHED -- requirements
Module: accum_loop_sched

Interface
REQ-001 Parameter DATA_W, default 8: operand, accumulator and result width.
REQ-002 Parameter CNT_W, default 3: loop-count width; iterations range 0 to 2^CNT_W-1.
REQ-003 One clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req0_valid / req1_valid  in  1 each  requester 0/1 has a job pending.
REQ-007 req0_ready / req1_ready  out  1 each  job accepted this cycle when both valid and ready are high.
REQ-008 req0_a / req1_a  in  DATA_W  initial accumulator value.
REQ-009 req0_b / req1_b  in  DATA_W  addend.
REQ-010 req0_count / req1_count  in  CNT_W  number of add iterations.
REQ-011 rsp_valid  out  1  result available.
REQ-012 rsp_ready  in  1  consumer takes the result.
REQ-013 rsp_result  out  DATA_W  final accumulator value.
REQ-014 rsp_overflow  out  1  at least one iteration was suppressed by overflow.
REQ-015 rsp_id  out  1  index of the requester that owns the result.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 States: IDLE, RUN, DONE; one job in flight at a time.
REQ-018 req*_ready SHALL be high only in IDLE, and only for the granted requester; at most one ready is high per cycle.
REQ-019 Grant: round-robin; with one requester valid, that requester wins; with both valid, the one not served last wins; the pointer updates only on acceptance.
REQ-020 On acceptance: acc <= a, ovf <= 0, iter <= count, id <= grant; next state is RUN if count != 0, else DONE.
REQ-021 RUN: each cycle, compute the DATA_W+1-bit sum acc+b. If the carry is set, ovf <= 1 and acc is held; otherwise acc <= sum. iter decrements, and the block moves to DONE after the iteration where iter == 1.
REQ-022 An overflowed iteration SHALL still consume one iteration; later iterations keep trying, so ovf is sticky but acc can still never exceed 2^DATA_W-1.
REQ-023 Latency: for acceptance at edge E0, rsp_valid SHALL be high in the cycle after edge E0+count (count = 0 -> the cycle right after acceptance).
REQ-024 DONE: rsp_valid is high, and rsp_result, rsp_overflow and rsp_id are stable until the edge where rsp_ready is high; that edge returns the block to IDLE.
REQ-025 No acceptance in the DONE cycle that completes the handshake; the next acceptance is possible in the following IDLE cycle at the earliest.
REQ-026 Requester inputs are sampled only at acceptance; changes during RUN have no effect.
REQ-027 rsp_result, rsp_overflow and rsp_id SHALL be driven from registers, not combinationally from the inputs.

Reset
REQ-028 While rst is high, regardless of clk: state = IDLE; acc, iter, ovf and id = 0; the RR pointer favours requester 0.
REQ-029 Reset-value outputs: rsp_valid 0, rsp_result 0, rsp_overflow 0, rsp_id 0, busy 0, all req*_ready 0 while rst is high.
REQ-030 Reset asserted during RUN or DONE drops the job silently; no response is produced for it.

Structure
REQ-031 Package accum_sched_pkg SHALL hold the state enum typedef and the default DATA_W/CNT_W constants.
REQ-032 The round-robin grant SHALL be a sub-module rr_arb2 (inputs: req[1:0], pointer update strobe; output: one-hot grant).

Verification
REQ-033 req0 a=10, b=20, count=3, rsp_ready=1 -> rsp_result=70, overflow=0, id=0, rsp_valid in the 4th cycle after acceptance.
REQ-034 req1 a=200, b=30, count=3 -> iterations: 230, hold, hold -> result=230, overflow=1, id=1.
REQ-035 count=0, a=0x5A -> result=0x5A, overflow=0, rsp_valid in the cycle right after acceptance.
REQ-036 Both requesters valid continuously with count=1 -> grants alternate 0,1,0,1, and each result is held while rsp_ready=0 for 3 cycles.
REQ-037 Assert rst in the second RUN cycle of a count=7 job -> outputs go to reset values immediately, no rsp_valid, and the next job completes normally.
